demux1to4_buf: RTL and testbench

Registered 1-to-4 demultiplexer. It routes a single valid/ready input stream to one of four output channels, chosen by a 2-bit select. Each output channel has a one-entry holding register, so an output stalled by its consumer does not block traffic to the other channels. The block is the distribution end of the 4-to-1 selection path: one source fans out to four sinks. Each channel keeps a delivered-word counter for debug and verification.

---
 rtl/demux1to4_buf.sv | 98 +++++++++
 tb/tb_demux1to4_buf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_buf.sv
//------------------------------------------------------------------------------
// Module   : demux1to4_buf
// Purpose  : Registered 1-to-4 demultiplexer. A single valid/ready input
//            stream is routed to one of four output channels chosen by sel.
//            Each channel owns a one-entry holding register so that a stalled
//            consumer only blocks traffic aimed at its own channel. Each
//            channel also counts delivered words (wrapping, debug only).
// Ports    : clk, rst       - clock, synchronous active-high reset
//            in_valid/in_ready/in_data/sel - input stream and destination
//            out_valid[3:0]/out_ready[3:0] - per-channel output handshake
//            out0..out3     - per-channel held data word
//            cnt0..cnt3     - per-channel delivered-word counters
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux1to4_buf #(
   parameter int W  = 8,
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [1:0]    sel,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   output logic [W-1:0]  out0,
   output logic [W-1:0]  out1,
   output logic [W-1:0]  out2,
   output logic [W-1:0]  out3,
   output logic [CW-1:0] cnt0,
   output logic [CW-1:0] cnt1,
   output logic [CW-1:0] cnt2,
   output logic [CW-1:0] cnt3
);

   logic [3:0]    valid_q;
   logic [W-1:0]  data_q [4];
   logic [CW-1:0] cnt_q  [4];
   logic          accept;

   // Readiness looks only at the selected channel: a full slot can still
   // take a word if its consumer drains it on this same edge.
   always_comb begin
      in_ready = !rst && (!valid_q[sel] || out_ready[sel]);
      accept   = in_valid && in_ready;
   end

   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_ch
         logic          acc;
         logic          dlv;
         logic          valid_d;
         logic [W-1:0]  data_d;
         logic [CW-1:0] cnt_d;

         always_comb begin
            acc     = accept && (sel == 2'(k));
            dlv     = valid_q[k] && out_ready[k];
            // A new word wins over a delivery so back-to-back words keep
            // the slot occupied at full throughput.
            valid_d = acc ? 1'b1 : (dlv ? 1'b0 : valid_q[k]);
            data_d  = acc ? in_data : data_q[k];
            cnt_d   = dlv ? cnt_q[k] + CW'(1) : cnt_q[k];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q[k] <= 1'b0;
               data_q[k]  <= '0;
               cnt_q[k]   <= '0;
            end else begin
               valid_q[k] <= valid_d;
               data_q[k]  <= data_d;
               cnt_q[k]   <= cnt_d;
            end
         end
      end
   endgenerate

   always_comb begin
      out_valid = valid_q;
      out0      = data_q[0];
      out1      = data_q[1];
      out2      = data_q[2];
      out3      = data_q[3];
      cnt0      = cnt_q[0];
      cnt1      = cnt_q[1];
      cnt2      = cnt_q[2];
      cnt3      = cnt_q[3];
   end

endmodule

`default_nettype wire

// File: tb/tb_demux1to4_buf.sv
//------------------------------------------------------------------------------
// Module   : tb_demux1to4_buf
// Purpose  : Directed self-checking bench for demux1to4_buf. Inputs change
//            1 time unit after a rising edge; outputs are sampled there too.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux1to4_buf;

   localparam int W  = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic [1:0]    sel;
   logic [3:0]    out_valid;
   logic [3:0]    out_ready;
   logic [W-1:0]  out0, out1, out2, out3;
   logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   demux1to4_buf #(.W(W), .CW(CW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .out1      (out1),
      .out2      (out2),
      .out3      (out3),
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] out_of(input int k);
      case (k)
         0:       return out0;
         1:       return out1;
         2:       return out2;
         default: return out3;
      endcase
   endfunction

   function automatic logic [CW-1:0] cnt_of(input int k);
      case (k)
         0:       return cnt0;
         1:       return cnt1;
         2:       return cnt2;
         default: return cnt3;
      endcase
   endfunction

   task automatic chk_cnts(input string tag, input int c0, input int c1, input int c2, input int c3);
      chk({tag, "_cnt0"}, 32'(cnt0), 32'(c0));
      chk({tag, "_cnt1"}, 32'(cnt1), 32'(c1));
      chk({tag, "_cnt2"}, 32'(cnt2), 32'(c2));
      chk({tag, "_cnt3"}, 32'(cnt3), 32'(c3));
   endtask

   task automatic chk_clear(input string tag);
      chk({tag, "_valid"}, 32'(out_valid), 32'h0);
      for (int k = 0; k < 4; k++) chk({tag, "_out"}, 32'(out_of(k)), 32'h0);
      chk_cnts(tag, 0, 0, 0, 0);
   endtask

   logic [W-1:0] words [4];

   initial begin
      words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hEE;
      sel       = 2'd0;
      out_ready = 4'hF;

      // Reset for two cycles; no handshake while reset is high.
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("rst_in_ready2", 32'(in_ready), 32'h0);
      tick();
      chk_clear("reset");
      rst      = 1'b0;
      in_valid = 1'b0;

      // Route one word to each channel with all consumers ready.
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         sel      = 2'(k);
         in_data  = words[k];
         #1;
         chk("route_in_ready", 32'(in_ready), 32'h1);
         @(posedge clk); #1;
         chk("route_valid", 32'(out_valid), 32'(4'b0001 << k));
         chk("route_data", 32'(out_of(k)), 32'(words[k]));
      end
      in_valid = 1'b0;
      tick();
      chk("route_drain_valid", 32'(out_valid), 32'h0);
      chk_cnts("route", 1, 1, 1, 1);

      // Back-pressure isolation: channel 2 stalled.
      out_ready = 4'b1011;
      in_valid  = 1'b1;
      sel       = 2'd2;
      in_data   = 8'h55;
      #1;
      chk("bp_ready_55", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk("bp_out2_55", 32'(out2), 32'h55);
      in_data = 8'h66;
      #1;
      chk("bp_ready_66", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk("bp_out2_held", 32'(out2), 32'h55);
      chk("bp_valid2", 32'(out_valid), 32'b0100);
      sel     = 2'd1;
      in_data = 8'h77;
      #1;
      chk("bp_ready_77", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk("bp_out1_77", 32'(out1), 32'h77);
      chk("bp_out2_still", 32'(out2), 32'h55);
      chk("bp_valid12", 32'(out_valid), 32'b0110);
      in_valid = 1'b0;
      tick();
      chk("bp_valid_after1", 32'(out_valid), 32'b0100);
      out_ready = 4'hF;
      tick();
      chk("bp_valid_after2", 32'(out_valid), 32'h0);
      chk_cnts("bp", 1, 2, 2, 1);

      // Full throughput on channel 3.
      in_valid = 1'b1;
      sel      = 2'd3;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i);
         #1;
         chk("tp_ready", 32'(in_ready), 32'h1);
         @(posedge clk); #1;
         chk("tp_out3", 32'(out3), 32'(i));
         chk("tp_valid3", 32'(out_valid[3]), 32'h1);
      end
      in_valid = 1'b0;
      tick();
      chk("tp_valid_drained", 32'(out_valid), 32'h0);
      chk("tp_cnt3", 32'(cnt3), 32'd17);   // 1 from routing + 16 streamed

      // Drain and refill on channel 0 in the same edge.
      out_ready = 4'h0;
      in_valid  = 1'b1;
      sel       = 2'd0;
      in_data   = 8'h11;
      tick();
      chk("dr_out0_11", 32'(out0), 32'h11);
      out_ready = 4'b0001;
      in_data   = 8'h22;
      #1;
      chk("dr_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk("dr_valid0", 32'(out_valid), 32'b0001);
      chk("dr_out0_22", 32'(out0), 32'h22);
      chk("dr_cnt0", 32'(cnt0), 32'd2);
      in_valid = 1'b0;
      tick();
      chk("dr_cnt0_after", 32'(cnt0), 32'd3);

      // Reset mid-operation with ch0 and ch2 holding stalled words.
      out_ready = 4'h0;
      in_valid  = 1'b1;
      sel       = 2'd0;
      in_data   = 8'h3C;
      tick();
      sel     = 2'd2;
      in_data = 8'h4D;
      tick();
      chk("mr_valid_pre", 32'(out_valid), 32'b0101);
      chk("mr_out2_pre", 32'(out2), 32'h4D);
      rst     = 1'b1;
      sel     = 2'd1;
      in_data = 8'hBB;
      #1;
      chk("mr_in_ready_rst", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
      chk_clear("midrst");
      rst     = 1'b0;
      in_data = 8'h9A;
      #1;
      chk("mr_ready_resume", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      chk("mr_out1_9a", 32'(out1), 32'h9A);
      chk("mr_valid_resume", 32'(out_valid), 32'b0010);

      // Counter wrap on ch1: 255 deliveries while streaming, then one more.
      out_ready = 4'b0010;
      for (int i = 0; i < 255; i++) begin
         in_data = 8'(i);
         tick();
         if (i == 127) chk("wrap_cnt1_128", 32'(cnt1), 32'd128);
      end
      chk("wrap_cnt1_255", 32'(cnt1), 32'd255);
      in_valid = 1'b0;
      tick();
      chk("wrap_cnt1_0", 32'(cnt1), 32'd0);
      chk("wrap_valid", 32'(out_valid), 32'h0);
      chk("wrap_cnt0", 32'(cnt_of(0)), 32'd0);
      chk("wrap_cnt2", 32'(cnt_of(2)), 32'd0);
      chk("wrap_cnt3", 32'(cnt_of(3)), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
